// File: rtl/microwave_pkg.sv
// Shared types and helpers for the parametrised microwave controller.
package microwave_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCook  = 3'd1,
    StPause = 3'd2,
    StDone  = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    ModeManual  = 2'b00,
    ModePresetA = 2'b01,
    ModePresetB = 2'b10,
    ModeDefrost = 2'b11
  } mode_e;

  // Zero means "lowest", over-range clamps; defrost halves but never drops to zero.
  function automatic int unsigned clamp_level(input int unsigned lvl, input int unsigned max_lvl,
                                              input logic defrost);
    int unsigned l;
    l = (lvl == 32'd0) ? 32'd1 : ((lvl > max_lvl) ? max_lvl : lvl);
    if (defrost) l = ((l >> 1) == 32'd0) ? 32'd1 : (l >> 1);
    return l;
  endfunction

endpackage

// File: rtl/cook_history_buf.sv
// Circular log of completed cook times; index 0 reads the most recent entry.
module cook_history_buf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 13,
  localparam int unsigned IdxW = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            wr_en_i,
  input  logic [W-1:0]    wr_data_i,
  input  logic            rd_en_i,
  input  logic [IdxW-1:0] rd_idx_i,
  output logic [W-1:0]    rd_data_o,
  output logic [IdxW:0]   count_o
);

  logic [W-1:0]    mem_q [DEPTH];
  logic [IdxW-1:0] wptr_q;
  logic [IdxW:0]   count_q;
  logic [W-1:0]    rd_data_q;
  logic [IdxW-1:0] rd_addr;

  // Power-of-two depth makes the modular walk back from the write pointer free.
  assign rd_addr = wptr_q - 1'b1 - rd_idx_i;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wptr_q    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en_i) begin
        wptr_q <= wptr_q + 1'b1;
        if (count_q != (IdxW + 1)'(DEPTH)) count_q <= count_q + 1'b1;
      end
      if (rd_en_i) begin
        rd_data_q <= ({1'b0, rd_idx_i} < count_q) ? mem_q[rd_addr] : '0;
      end
    end
  end

  // Storage needs no reset: stale entries are hidden behind count_q.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;

endmodule

// File: rtl/microwave_ctrl_p.sv
// Microwave controller: timed cook with pause, presets, defrost, door interlock and history.
module microwave_ctrl_p
  import microwave_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned TIME_W        = 13,
  parameter int unsigned MAX_SEC       = 5999,
  parameter int unsigned STEP_SEC      = 30,
  parameter int unsigned HEAT_W        = 4,
  parameter int unsigned MAX_LEVEL     = 10,
  parameter int unsigned PRESET_A      = 60,
  parameter int unsigned PRESET_B      = 120,
  parameter int unsigned PRESET_D      = 300,
  parameter int unsigned BEEP_SEC      = 3,
  parameter int unsigned HIST_DEPTH    = 8,
  localparam int unsigned HistIdxW     = $clog2(HIST_DEPTH)
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                door_i,
  input  logic                inc_i,
  input  logic                dec_i,
  input  logic [1:0]          mode_i,
  input  logic [HEAT_W-1:0]   level_in_i,
  input  logic                hist_rd_en_i,
  input  logic [HistIdxW-1:0] hist_rd_idx_i,
  output logic                lamp_door_o,
  output logic [HEAT_W-1:0]   heat_o,
  output logic [TIME_W-1:0]   remaining_sec_o,
  output logic [2:0]          state_o,
  output logic                done_pulse_o,
  output logic                beep_o,
  output logic [TIME_W-1:0]   hist_rd_data_o,
  output logic [HistIdxW:0]   hist_count_o
);

  localparam int unsigned PreW  = $clog2(TICKS_PER_SEC + 1);
  localparam int unsigned BeepW = $clog2(BEEP_SEC + 1);

  state_e              state_q, state_d;
  logic [TIME_W-1:0]   rem_q, rem_d, prog_q, prog_d;
  logic [PreW-1:0]     pre_q, pre_d;
  logic [HEAT_W-1:0]   level_q, level_d;
  logic [BeepW-1:0]    beep_sec_q, beep_sec_d;
  logic                done_q, done_d;
  logic                start_q, stop_q, inc_q, dec_q;
  logic                start_edge, stop_edge, inc_edge, dec_edge;
  logic                tick, hist_we;

  assign start_edge = start_i & ~start_q;
  assign stop_edge  = stop_i & ~stop_q;
  assign inc_edge   = inc_i & ~inc_q;
  assign dec_edge   = dec_i & ~dec_q;
  assign tick       = (pre_q == PreW'(TICKS_PER_SEC - 1));

  function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] x);
    logic [TIME_W:0] s;
    s = {1'b0, x} + (TIME_W + 1)'(STEP_SEC);
    return (s > (TIME_W + 1)'(MAX_SEC)) ? TIME_W'(MAX_SEC) : s[TIME_W-1:0];
  endfunction

  function automatic logic [TIME_W-1:0] sat_sub(input logic [TIME_W-1:0] x);
    return (x >= TIME_W'(STEP_SEC)) ? x - TIME_W'(STEP_SEC) : '0;
  endfunction

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    prog_d     = prog_q;
    pre_d      = pre_q;
    level_d    = level_q;
    beep_sec_d = beep_sec_q;
    done_d     = 1'b0;
    hist_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // An ignored start still consumes the cycle, so inc/dec lose to it.
        if (!door_i && !stop_edge) begin
          if (start_edge) begin
            case (mode_e'(mode_i))
              ModePresetA: rem_d = TIME_W'(PRESET_A);
              ModePresetB: rem_d = TIME_W'(PRESET_B);
              ModeDefrost: rem_d = TIME_W'(PRESET_D);
              default:     rem_d = rem_q;
            endcase
            if (rem_d != '0) begin
              state_d = StCook;
              pre_d   = '0;
              prog_d  = rem_d;
              level_d = HEAT_W'(clamp_level(32'(level_in_i), MAX_LEVEL, mode_i == ModeDefrost));
            end
          end else if (inc_edge && !dec_edge) begin
            rem_d = sat_add(rem_q);
          end else if (dec_edge && !inc_edge) begin
            rem_d = sat_sub(rem_q);
          end
        end
      end
      StCook: begin
        if (door_i || stop_edge) begin
          state_d = StPause;
        end else begin
          if (start_edge) begin
            rem_d  = sat_add(rem_q);
            prog_d = sat_add(prog_q);
          end
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            rem_d = rem_d - 1'b1;
            if (rem_d == '0) begin
              state_d    = StDone;
              done_d     = 1'b1;
              hist_we    = 1'b1;
              pre_d      = '0;
              beep_sec_d = '0;
            end
          end
        end
      end
      StPause: begin
        if (!door_i) begin
          if (stop_edge) begin
            state_d = StIdle;
            rem_d   = '0;
          end else if (start_edge) begin
            state_d = StCook;
          end
        end
      end
      StDone: begin
        if (door_i || stop_edge) begin
          state_d = StIdle;
        end else begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            if (beep_sec_q == BeepW'(BEEP_SEC - 1)) state_d = StIdle;
            else beep_sec_d = beep_sec_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      prog_q     <= '0;
      pre_q      <= '0;
      level_q    <= '0;
      beep_sec_q <= '0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      prog_q     <= prog_d;
      pre_q      <= pre_d;
      level_q    <= level_d;
      beep_sec_q <= beep_sec_d;
      done_q     <= done_d;
      start_q    <= start_i;
      stop_q     <= stop_i;
      inc_q      <= inc_i;
      dec_q      <= dec_i;
    end
  end

  cook_history_buf #(
    .DEPTH (HIST_DEPTH),
    .W     (TIME_W)
  ) u_hist (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .wr_en_i   (hist_we),
    .wr_data_i (prog_d),
    .rd_en_i   (hist_rd_en_i),
    .rd_idx_i  (hist_rd_idx_i),
    .rd_data_o (hist_rd_data_o),
    .count_o   (hist_count_o)
  );

  // Heat is gated by the live door input so opening it kills power in the same cycle.
  assign heat_o          = (state_q == StCook && !door_i) ? level_q : '0;
  assign lamp_door_o     = door_i | (state_q == StCook);
  assign remaining_sec_o = rem_q;
  assign state_o         = state_q;
  assign done_pulse_o    = done_q;
  assign beep_o          = (state_q == StDone);

endmodule

// File: tb/tb_microwave_ctrl_p.sv
// Randomised and directed bench for microwave_ctrl_p against a tick-count reference model.
module tb_microwave_ctrl_p;

  localparam int T    = 4;
  localparam int STEP = 30;
  localparam int MAXS = 5999;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, door = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] level_in = 4'd0;
  logic       rd_en = 1'b0;
  logic [2:0] rd_idx = 3'd0;
  logic        lamp_door, done_pulse, beep;
  logic [3:0]  heat;
  logic [12:0] remaining_sec, hist_rd_data;
  logic [2:0]  state;
  logic [3:0]  hist_count;

  microwave_ctrl_p #(
    .TICKS_PER_SEC (T),
    .STEP_SEC      (STEP)
  ) dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .start_i         (start),
    .stop_i          (stop),
    .door_i          (door),
    .inc_i           (inc),
    .dec_i           (dec),
    .mode_i          (mode),
    .level_in_i      (level_in),
    .hist_rd_en_i    (rd_en),
    .hist_rd_idx_i   (rd_idx),
    .lamp_door_o     (lamp_door),
    .heat_o          (heat),
    .remaining_sec_o (remaining_sec),
    .state_o         (state),
    .done_pulse_o    (done_pulse),
    .beep_o          (beep),
    .hist_rd_data_o  (hist_rd_data),
    .hist_count_o    (hist_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: remaining time held as ticks left until completion.
  int m_state = 0, m_rem = 0, m_ticks = 0, m_prog = 0, m_level = 0;
  int m_beep_left = 0, m_done = 0, m_rd_data = 0;
  int hist[$];
  bit p_start = 0, p_stop = 0, p_inc = 0, p_dec = 0;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int model_rem();
    return (m_state == 1 || m_state == 2) ? (m_ticks + T - 1) / T : m_rem;
  endfunction

  task automatic model_step();
    bit se, te, ie, de;
    int r, p, lv;
    if (!reset_n) begin
      m_state = 0; m_rem = 0; m_ticks = 0; m_prog = 0; m_level = 0;
      m_beep_left = 0; m_done = 0; m_rd_data = 0;
      hist.delete();
      p_start = 0; p_stop = 0; p_inc = 0; p_dec = 0;
      return;
    end
    se = start && !p_start; te = stop && !p_stop;
    ie = inc && !p_inc;     de = dec && !p_dec;
    p_start = start; p_stop = stop; p_inc = inc; p_dec = dec;
    m_done = 0;
    if (rd_en) m_rd_data = (int'(rd_idx) < hist.size()) ? hist[rd_idx] : 0;
    case (m_state)
      0: if (!door && !te) begin
        if (se) begin
          r = (mode == 2'd1) ? 60 : (mode == 2'd2) ? 120 : (mode == 2'd3) ? 300 : m_rem;
          if (r > 0) begin
            lv = (level_in == 0) ? 1 : ((level_in > 10) ? 10 : int'(level_in));
            if (mode == 2'd3) lv = (lv / 2 < 1) ? 1 : lv / 2;
            m_level = lv; m_prog = r; m_ticks = r * T; m_state = 1;
          end
        end else if (ie && !de) m_rem = min_i(m_rem + STEP, MAXS);
        else if (de && !ie) m_rem = (m_rem >= STEP) ? m_rem - STEP : 0;
      end
      1: if (door || te) m_state = 2;
      else begin
        if (se) begin
          r = (m_ticks + T - 1) / T;
          p = r * T - m_ticks;
          m_ticks = min_i(r + STEP, MAXS) * T - p;
          m_prog = min_i(m_prog + STEP, MAXS);
        end
        m_ticks--;
        if (m_ticks == 0) begin
          m_state = 3; m_done = 1; m_rem = 0; m_beep_left = 3 * T;
          hist.push_front(m_prog);
          if (hist.size() > 8) void'(hist.pop_back());
        end
      end
      2: if (!door) begin
        if (te) begin m_state = 0; m_rem = 0; end
        else if (se) m_state = 1;
      end
      default: if (door || te) m_state = 0;
      else begin
        m_beep_left--;
        if (m_beep_left == 0) m_state = 0;
      end
    endcase
  endtask

  task automatic compare_model();
    if (bad >= 200) return;
    check_val("state", int'(state), m_state);
    check_val("rem", int'(remaining_sec), model_rem());
    check_val("heat", int'(heat), (m_state == 1 && !door) ? m_level : 0);
    check_val("lamp", int'(lamp_door), int'(door) | int'(m_state == 1));
    check_val("done_pulse", int'(done_pulse), m_done);
    check_val("beep", int'(beep), int'(m_state == 3));
    check_val("hist_count", int'(hist_count), hist.size());
    check_val("hist_data", int'(hist_rd_data), m_rd_data);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  // b = {start, stop, inc, dec}; hold one cycle then release one cycle.
  task automatic press(input logic [3:0] b);
    {start, stop, inc, dec} = b;
    cycle();
    {start, stop, inc, dec} = 4'b0000;
    cycle();
  endtask

  task automatic cancel();
    press(4'b0100);
    press(4'b0100);
  endtask

  task automatic hist_read(input int idx);
    rd_en = 1'b1;
    rd_idx = 3'(idx);
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic wait_state(input int st, input int budget, input string tag);
    int n;
    n = 0;
    while (int'(state) != st && n < budget) begin
      cycle();
      n++;
    end
    if (int'(state) != st) check_val(tag, int'(state), st);
  endtask

  task automatic run_cook(input int k);
    mode = 2'd0;
    for (int i = 0; i < k; i++) press(4'b0010);
    level_in = 4'($urandom_range(0, 15));
    press(4'b1000);
    wait_state(0, k * 120 + 40, "cook_timeout");
  endtask

  int n, rem_before;

  initial begin
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    check_val("rst_state", int'(state), 0);
    check_val("rst_rem", int'(remaining_sec), 0);
    check_val("rst_count", int'(hist_count), 0);
    check_val("rst_beep", int'(beep), 0);

    // Manual cook of 60 s
    press(4'b0010);
    press(4'b0010);
    check_val("inc_x2", int'(remaining_sec), 60);
    level_in = 4'd7;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_val("heat_7", int'(heat), 7);
    n = 0;
    while (int'(state) != 3 && n < 300) begin
      cycle();
      n++;
    end
    check_val("cook_cycles", n, 240);
    check_val("done_pulse_hi", int'(done_pulse), 1);
    cycle();
    check_val("done_pulse_lo", int'(done_pulse), 0);
    wait_state(0, 20, "beep_timeout");
    hist_read(0);
    check_val("hist_idx0_60", int'(hist_rd_data), 60);
    check_val("hist_count_1", int'(hist_count), 1);

    // Door interlock and resume
    press(4'b0010);
    press(4'b0010);
    press(4'b1000);
    n = 0;
    while (int'(remaining_sec) != 40 && n < 200) begin
      cycle();
      n++;
    end
    check_val("reach_40", int'(remaining_sec), 40);
    door = 1'b1;
    #1;
    check_val("heat_door_comb", int'(heat), 0);
    cycle();
    check_val("pause_state", int'(state), 2);
    cycle();
    cycle();
    check_val("pause_hold", int'(remaining_sec), 40);
    door = 1'b0;
    cycle();
    press(4'b1000);
    check_val("resume_state", int'(state), 1);
    check_val("resume_rem", int'(remaining_sec), 40);
    cycle();
    cycle();
    cycle();
    check_val("resume_tick", int'(remaining_sec), 39);
    cancel();
    check_val("cancel_rem", int'(remaining_sec), 0);

    // Saturation and guards
    for (int i = 0; i < 200; i++) press(4'b0010);
    check_val("sat_max", int'(remaining_sec), 5999);
    for (int i = 0; i < 199; i++) press(4'b0001);
    check_val("dec_29", int'(remaining_sec), 29);
    press(4'b0001);
    check_val("dec_floor", int'(remaining_sec), 0);
    press(4'b1000);
    check_val("start_zero_state", int'(state), 0);
    check_val("start_zero_heat", int'(heat), 0);

    // Defrost and level clamping
    mode = 2'd3;
    level_in = 4'd9;
    press(4'b1000);
    check_val("defrost_rem", int'(remaining_sec), 300);
    check_val("defrost_heat", int'(heat), 4);
    cancel();
    mode = 2'd0;
    level_in = 4'd0;
    press(4'b0010);
    press(4'b1000);
    check_val("level_0", int'(heat), 1);
    cancel();
    level_in = 4'd15;
    press(4'b0010);
    press(4'b1000);
    check_val("level_15", int'(heat), 10);
    cancel();

    // History wrap
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      run_cook(k);
      if (k == 3) begin
        hist_read(5);
        check_val("hist_oob", int'(hist_rd_data), 0);
        hist_read(2);
        check_val("hist_idx2_30", int'(hist_rd_data), 30);
      end
    end
    check_val("hist_full", int'(hist_count), 8);
    hist_read(0);
    check_val("hist_idx0_270", int'(hist_rd_data), 270);
    hist_read(7);
    check_val("hist_idx7_60", int'(hist_rd_data), 60);

    // Reset mid-cook, then start+stop together
    press(4'b0010);
    press(4'b1000);
    for (int i = 0; i < 5; i++) cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check_val("midrst_state", int'(state), 0);
    check_val("midrst_heat", int'(heat), 0);
    check_val("midrst_rem", int'(remaining_sec), 0);
    check_val("midrst_count", int'(hist_count), 0);
    press(4'b0010);
    press(4'b0010);
    press(4'b1000);
    cycle();
    rem_before = model_rem();
    {start, stop} = 2'b11;
    cycle();
    check_val("ss_state", int'(state), 2);
    check_val("ss_rem", int'(remaining_sec), rem_before);
    {start, stop} = 2'b00;
    cycle();
    press(4'b0100);

    // Random traffic
    for (int i = 0; i < 20000 && bad < 100; i++) begin
      if ($urandom_range(0, 149) == 0) start = ~start;
      if ($urandom_range(0, 99) == 0) stop = ~stop;
      if ($urandom_range(0, 5) == 0) inc = ~inc;
      if ($urandom_range(0, 9) == 0) dec = ~dec;
      if ($urandom_range(0, 79) == 0) door = ~door;
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom);
      level_in = 4'($urandom);
      rd_en = 1'($urandom);
      rd_idx = 3'($urandom);
      reset_n = ($urandom_range(0, 2999) != 0);
      if (door || !reset_n) #1;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microwave_ctrl_p.md
Name: microwave_ctrl_p

Overview:
Parametrised successor to the team's microwave controller. Adds a configurable time base, a configurable step size and time limit, per-cook power level, preset and defrost modes, pause/resume, and a zero-latency door interlock on heat. Completed cook times are logged in a circular history buffer that can be read back. Sits under the front-panel decoder; the display formatter consumes `remaining_sec` and `state`.

Parameters:
TICKS_PER_SEC, 100, clk cycles per cook second (small values for simulation)
TIME_W, 13, width of all second counters
MAX_SEC, 5999, saturation limit of remaining time
STEP_SEC, 30, seconds added/removed per inc/dec/quick-add
HEAT_W, 4, width of power level
MAX_LEVEL, 10, highest legal power level
PRESET_A, 60, mode 01 load value (s)
PRESET_B, 120, mode 10 load value (s)
PRESET_D, 300, mode 11 (defrost) load value (s)
BEEP_SEC, 3, beep duration in DONE
HIST_DEPTH, 8, history entries (power of 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  start/resume/quick-add button (level; rising edge used)
stop  in  1  pause/cancel button (level; rising edge used)
door  in  1  1 = door open
inc  in  1  add STEP_SEC (rising edge)
dec  in  1  subtract STEP_SEC (rising edge)
mode  in  2  00 manual, 01 preset A, 10 preset B, 11 defrost
level_in  in  HEAT_W  requested power, sampled on start
hist_rd_en  in  1  history read strobe
hist_rd_idx  in  log2(HIST_DEPTH)  0 = most recent entry
lamp_door  out  1  cavity lamp
heat  out  HEAT_W  magnetron power
remaining_sec  out  TIME_W  seconds left
state  out  3  FSM state code
done_pulse  out  1  one-cycle pulse on completion
beep  out  1  buzzer
hist_rd_data  out  TIME_W  history read data
hist_count  out  log2(HIST_DEPTH)+1  valid entries

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; remaining_sec=0, heat=0, done_pulse=0, beep=0, hist_count=0, hist_rd_data=0, prescaler=0, latched level=0. Applies mid-operation and clears history. lamp_door then follows the door input.
- All buttons are edge-detected internally (registered previous value).
- Priority within one cycle: reset > door open > stop > start > inc/dec.
- IDLE:
  - inc: remaining=min(rem+STEP_SEC, MAX_SEC). dec: rem>=STEP_SEC ? rem-STEP_SEC : 0. inc and dec together: no change.
  - start with door closed:
    - mode!=00 loads its preset.
    - mode 00 requires rem>0, otherwise ignored.
    - Latch level: 0 becomes 1, values >MAX_LEVEL clamp to MAX_LEVEL. Defrost uses max(level>>1, 1).
    - Clear prescaler and go to COOK. The "programmed" register holds the value at start plus all quick-adds.
- COOK:
  - Prescaler counts 0..TICKS_PER_SEC-1; at wrap, rem decrements.
  - When rem goes 1→0: go to DONE, done_pulse=1 for one cycle, write the programmed time to history.
  - start edge: quick-add STEP_SEC, saturating at MAX_SEC.
  - door=1 or stop edge: go to PAUSE, prescaler frozen (not cleared).
- PAUSE: start edge with door closed resumes COOK. stop edge goes to IDLE with rem=0; nothing is logged.
- DONE: beep=1 for BEEP_SEC seconds, then IDLE. door open or stop edge goes to IDLE immediately with beep=0.
- heat is combinational: latched level when state==COOK and door==0, else 0. Zero-cycle interlock.
- lamp_door is combinational: door | (state==COOK).
- State codes: IDLE=0, COOK=1, PAUSE=2, DONE=3.
- History buffer:
  - Circular; write pointer wraps and overwrites the oldest entry. hist_count saturates at HIST_DEPTH.
  - Read latency 1 cycle. An idx >= hist_count returns 0.
  - A read in the same cycle as a write returns pre-write contents; the index is relative to the old pointer.

Decomposition:
- microwave_pkg: state codes, mode codes, priority-clamp helper for level.
- Sub-module cook_history_buf (parameters DEPTH, W): write port, indexed read port, count.

Test Plan:
Common settings: TICKS_PER_SEC=4, STEP_SEC=30.
1. Manual cook: inc×2 → rem=60; level_in=7, start → heat=7, rem decrements every 4 cycles. After 240 cycles: state=3, done_pulse=1 for one cycle, hist_rd_data(idx0)=60, hist_count=1.
2. Door interlock: at rem=40 in COOK, door=1 → heat=0 the same cycle, state=2, rem holds 40. door=0 then start → state=1, rem continues from 40.
3. Saturation and guards: rem=5990, inc → 5999. rem=20, dec → 0. start with rem=0 in mode 00 → state stays 0, heat=0.
4. Defrost: mode=11, level_in=9, start → rem=300, heat=4. level_in=0 in mode 00 → heat=1. level_in=15 → heat=10.
5. History wrap: 9 cooks of 30,60,…,270 s → hist_count=8, idx0=270, idx7=60. idx8 is out of range (too wide for the 3-bit index at depth 8): verify instead that a read with idx >= hist_count before the buffer fills returns 0.
6. Reset mid-cook and simultaneity:
   - reset=0 for one cycle during COOK → state=0, heat=0, rem=0, hist_count=0.
   - start and stop edges in the same cycle in COOK → PAUSE, no quick-add.
